// File: rtl/proc_pkg.sv
// Shared types and default widths for the memory burst reader.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_OUT,
    DONE
  } state_t;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_LEN_W  = 8;

endpackage

// File: rtl/addr_counter.sv
// Loadable, incrementing address register; load wins over increment.
module addr_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (load) count <= load_value;
    else if (inc)  count <= count + 1'b1;
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Reads a burst of words from memory and streams them out one at a time.
// Optional ack-wait timeout enabled by defining MEM_BURST_READER_TIMEOUT_EN.
module mem_burst_reader
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned LEN_W          = DEF_LEN_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t             state, state_next;
  logic [LEN_W-1:0]   remaining;
  logic               launch;
  logic               capture;
  logic               handshake;
  logic               timeout_hit;

  assign launch    = (state == IDLE) && start && (burst_len != '0);
  assign capture   = (state == REQ) && mem_ack;
  assign handshake = (state == WAIT_OUT) && out_valid && out_ready;

  addr_counter #(.W(ADDR_W)) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (launch),
    .inc       (capture),
    .load_value(start_addr),
    .count     (mem_addr)
  );

`ifdef MEM_BURST_READER_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;

  assign timeout_hit = (state == REQ) && !mem_ack &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Holding the counter at zero outside REQ clears it on every entry to REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (state != REQ)    wait_cnt <= '0;
    else if (!mem_ack)        wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              timed_out <= 1'b0;
    else if (timeout_hit)    timed_out <= 1'b1;
    else if (state == DONE)  timed_out <= 1'b0;
  end

  assign err = (state == DONE) && timed_out;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = (burst_len != '0) ? REQ : DONE;
      REQ:      if (mem_ack)          state_next = WAIT_OUT;
                else if (timeout_hit) state_next = DONE;
      WAIT_OUT: if (handshake) state_next = (remaining == '0) ? DONE : REQ;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign mem_rd = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (launch)       remaining <= burst_len;
      else if (capture) remaining <= remaining - 1'b1;
      if (capture) begin
        out_data  <= mem_rdata;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
